// File: rtl/multi_edge_counter.sv
// multi_edge_counter: multi-channel windowed edge counter emitting timestamped records to the RTI FIFO.
// Define MULTI_EDGE_COUNTER_SAT_EN for saturating counters with a per-record saturation flag.
module multi_edge_counter #(
   parameter int NUM_CH      = 4,
   parameter int COUNT_WIDTH = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              s_axi_aclk,
   input  logic              s_axi_aresetn,
   input  logic [NUM_CH-1:0] input_sig,
   input  logic [63:0]       counter,
   input  logic              cmd_valid,
   input  logic [63:0]       cmd_in,
   input  logic              fifo_full,
   output logic              write,
   output logic [127:0]      count_out,
   output logic              busy,
   output logic              cmd_error
);
   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   typedef enum logic [1:0] {IDLE, COUNT, DUMP} state_t;
   state_t                 state;
   logic [NUM_CH-1:0]      sync_q [SYNC_STAGES];
   logic [NUM_CH-1:0]      prev, rise_q, fall_q, mask, inc, sat;
   logic [1:0]             mode;
   logic [COUNT_WIDTH-1:0] cnt [NUM_CH];
   logic [63:0]            ts;
   logic [IW-1:0]          idx;
   logic                   start, stop, clr, last, unused_cmd;
   assign start      = cmd_valid && cmd_in[1:0] == 2'b01;
   assign stop       = cmd_valid && cmd_in[1:0] == 2'b10;
   assign clr        = cmd_valid && cmd_in[1:0] == 2'b11;
   assign last       = idx == IW'(NUM_CH - 1);
   assign unused_cmd = ^cmd_in;
   assign inc        = mask & (({NUM_CH{mode[0]}} & rise_q) | ({NUM_CH{mode[1]}} & fall_q));
   assign busy       = state != IDLE;
   // Gated combinationally so a full FIFO or a CLEAR in the same cycle blocks the write.
   assign write      = state == DUMP && mask[idx] && !fifo_full && !clr;
   always_comb begin
      count_out = '0;
      if (state == DUMP && mask[idx]) begin
         count_out[127:64]            = ts;
         count_out[63:56]             = 8'(idx);
         count_out[48]                = sat[idx];
         count_out[COUNT_WIDTH-1:0]   = cnt[idx];
      end
   end
   // Edge pulses are registered, giving SYNC_STAGES+2 cycles from input toggle to count.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
      if (!s_axi_aresetn) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         prev   <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         sync_q[0] <= input_sig;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev   <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev;
         fall_q <= ~sync_q[SYNC_STAGES-1] & prev;
      end
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
      if (!s_axi_aresetn) begin
         state     <= IDLE;
         mask      <= '0;
         mode      <= '0;
         sat       <= '0;
         ts        <= '0;
         idx       <= '0;
         cmd_error <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      end else begin
         cmd_error <= (stop && state == IDLE) || (start && state != IDLE) || (stop && state == DUMP);
         if (clr) begin
            state <= IDLE;
            idx   <= '0;
            sat   <= '0;
            for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
         end else if (state == IDLE) begin
            if (start) begin
               mask  <= cmd_in[8 +: NUM_CH];
               mode  <= cmd_in[17:16];
               sat   <= '0;
               state <= COUNT;
               for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
            end
         end else if (state == COUNT) begin
            for (int c = 0; c < NUM_CH; c++) begin
`ifdef MULTI_EDGE_COUNTER_SAT_EN
               if (inc[c] && &cnt[c]) sat[c] <= 1'b1;
               else if (inc[c]) cnt[c] <= cnt[c] + 1'b1;
`else
               if (inc[c]) cnt[c] <= cnt[c] + 1'b1;
`endif
            end
            if (stop) begin
               ts    <= counter;
               idx   <= '0;
               state <= DUMP;
            end
         end else if (!mask[idx] || !fifo_full) begin
            idx <= idx + 1'b1;
            if (last) state <= IDLE;
         end
      end
endmodule
